// File: rtl/hazard_ctrl_if.sv
// Pipeline/hazard-controller bundle for the 5-stage core.
// master: pipeline side (drives stage fields, receives controls)
// slave : hazard controller side
interface hazard_ctrl_if #(
  parameter int RAW = 5
);
  // decode stage
  logic           D_valid;
  logic [RAW-1:0] D_ra;
  logic [RAW-1:0] D_rb;
  logic           D_ld;
  logic           D_addi;
  // execute stage
  logic           E_valid;
  logic [RAW-1:0] E_ra;
  logic [RAW-1:0] E_rb;
  logic [RAW-1:0] E_rd;
  logic           E_we;
  logic           E_ld;
  logic           E_mul;
  logic           E_brn_taken;
  // memory stage
  logic [RAW-1:0] M_rd;
  logic           M_we;
  logic           M_ld;
  // writeback stage
  logic [RAW-1:0] W_rd;
  logic           W_we;
  // controls back to the pipeline
  logic           F_stall;
  logic           D_stall;
  logic           E_stall;
  logic           F_flush;
  logic           D_bubble;
  logic           E_bubble;
  logic [1:0]     fwd_a;
  logic [1:0]     fwd_b;
  logic           mul_busy;
  logic           mul_done;

  modport master (
    output D_valid, D_ra, D_rb, D_ld, D_addi,
    output E_valid, E_ra, E_rb, E_rd, E_we, E_ld, E_mul, E_brn_taken,
    output M_rd, M_we, M_ld, W_rd, W_we,
    input  F_stall, D_stall, E_stall, F_flush, D_bubble, E_bubble,
    input  fwd_a, fwd_b, mul_busy, mul_done
  );

  modport slave (
    input  D_valid, D_ra, D_rb, D_ld, D_addi,
    input  E_valid, E_ra, E_rb, E_rd, E_we, E_ld, E_mul, E_brn_taken,
    input  M_rd, M_we, M_ld, W_rd, W_we,
    output F_stall, D_stall, E_stall, F_flush, D_bubble, E_bubble,
    output fwd_a, fwd_b, mul_busy, mul_done
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/bubble/flush sequencing, ALU operand forwarding and
// multi-cycle MUL occupancy of E for the 5-stage core.
// Optional: define HAZARD_PERF_EN to add lu_cnt, mul_stall_cnt and
// flush_cnt performance counters (32-bit, wrapping, cleared by rst).
module hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int RAW     = 5
) (
  input  logic        clk,
  input  logic        rst,
  hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] lu_cnt,
  output logic [31:0] mul_stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  localparam int             CW    = $clog2(MUL_LAT) + 1;
  localparam logic [CW-1:0]  LAST  = CW'(MUL_LAT - 1);
  localparam bit             MULTI = (MUL_LAT > 1);

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;

  logic [RAW-1:0] d_ra, d_rb, e_ra, e_rb, e_rd, m_rd, w_rd;
  logic           use_a, use_b, lu;
  logic           mul_stall, mul_done_c;
  logic           f_stall_c, d_stall_c, e_stall_c;
  logic           f_flush_c, d_bubble_c, e_bubble_c;
  logic [1:0]     fwd_a_c, fwd_b_c;

  assign d_ra = bus.D_ra;
  assign d_rb = bus.D_rb;
  assign e_ra = bus.E_ra;
  assign e_rb = bus.E_rb;
  assign e_rd = bus.E_rd;
  assign m_rd = bus.M_rd;
  assign w_rd = bus.W_rd;

  // ADDI and loads only read ra; every address bit is compared, r0 included
  assign use_a = bus.D_valid;
  assign use_b = bus.D_valid & ~bus.D_addi & ~bus.D_ld;
  assign lu    = bus.E_valid & bus.E_ld & bus.E_we &
                 ((use_a & (e_rd == d_ra)) | (use_b & (e_rd == d_rb)));

  // State register and MUL occupancy counter; reset aborts a MUL in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state plus stall/bubble/flush priority: rst > MUL > branch > load-use
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    mul_stall  = 1'b0;
    mul_done_c = 1'b0;
    f_stall_c  = 1'b0;
    d_stall_c  = 1'b0;
    e_stall_c  = 1'b0;
    f_flush_c  = 1'b0;
    d_bubble_c = 1'b0;
    e_bubble_c = 1'b0;

    case (state)
      IDLE: begin
        if (bus.E_valid && bus.E_mul) begin
          if (MULTI) begin
            mul_stall = 1'b1;
            state_nxt = MUL_BUSY;
            cnt_nxt   = CW'(1);
          end else begin
            mul_done_c = 1'b1;
          end
        end
      end
      MUL_BUSY: begin
        if (cnt < LAST) begin
          mul_stall = 1'b1;
          cnt_nxt   = cnt + CW'(1);
        end else begin
          mul_done_c = 1'b1;
          state_nxt  = IDLE;
          cnt_nxt    = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    if (rst) begin
      mul_done_c = 1'b0;
    end else if (mul_stall) begin
      // D is held, not bubbled, while the MUL occupies E
      f_stall_c  = 1'b1;
      d_stall_c  = 1'b1;
      e_stall_c  = 1'b1;
      e_bubble_c = 1'b1;
    end else if (bus.E_brn_taken) begin
      // redirect wins over a load-use stall so the new PC is taken
      f_flush_c  = 1'b1;
      d_bubble_c = 1'b1;
    end else if (lu) begin
      f_stall_c  = 1'b1;
      d_stall_c  = 1'b1;
      d_bubble_c = 1'b1;
    end
  end

  // Operand forwarding into E: youngest producer (M) wins, loads in M excluded
  always_comb begin
    fwd_a_c = 2'b00;
    fwd_b_c = 2'b00;
    if (!rst) begin
      if (bus.M_we && !bus.M_ld && (m_rd == e_ra))      fwd_a_c = 2'b10;
      else if (bus.W_we && (w_rd == e_ra))              fwd_a_c = 2'b01;
      if (bus.M_we && !bus.M_ld && (m_rd == e_rb))      fwd_b_c = 2'b10;
      else if (bus.W_we && (w_rd == e_rb))              fwd_b_c = 2'b01;
    end
  end

  assign bus.F_stall  = f_stall_c;
  assign bus.D_stall  = d_stall_c;
  assign bus.E_stall  = e_stall_c;
  assign bus.F_flush  = f_flush_c;
  assign bus.D_bubble = d_bubble_c;
  assign bus.E_bubble = e_bubble_c;
  assign bus.fwd_a    = fwd_a_c;
  assign bus.fwd_b    = fwd_b_c;
  assign bus.mul_busy = (state == MUL_BUSY) & ~rst;
  assign bus.mul_done = mul_done_c;

`ifdef HAZARD_PERF_EN
  // Event counters for load-use cycles, MUL stall cycles and flush cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt        <= '0;
      mul_stall_cnt <= '0;
      flush_cnt     <= '0;
    end else begin
      if (lu)        lu_cnt        <= lu_cnt + 32'd1;
      if (e_stall_c) mul_stall_cnt <= mul_stall_cnt + 32'd1;
      if (f_flush_c) flush_cnt     <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule
